// File: rtl/ct_spsram_256x54_access_ctrl.sv
// Initiator-side access controller for the 256x54 single-port SRAM wrapper.
//
// Turns a valid/ready read/write request channel into the SRAM's active-low
// CEN/GWEN/WEN pin protocol and returns read data through a 2-entry response
// FIFO with its own valid/ready handshake.
//
// Optional feature, macro CT_SPSRAM_ACCESS_CTRL_INIT_EN: after reset the whole
// array is swept to INIT_DATA (one entry per cycle) before requests are taken.
// Without the macro there is no sweep and init_done is constant 1.
//
// Ports:
//   forever_cpuclk, cpurst_b           clock, async active-low reset
//   req_vld/req_rdy/req_write/req_addr request channel
//   req_wdata/req_ben                  write data, active-high half enables
//   rsp_vld/rsp_rdy/rsp_data           read response channel (FIFO head)
//   init_done                          array ready, gates req_rdy
//   sram_a/cen/gwen/wen/d, sram_q      SRAM pins (combinational), SRAM Q
module ct_spsram_256x54_access_ctrl #(
  parameter int unsigned             ADDR_WIDTH = 8,
  parameter int unsigned             HALF_WIDTH = 27,
  parameter logic [2*HALF_WIDTH-1:0] INIT_DATA  = '0
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*HALF_WIDTH-1:0] req_wdata,
  input  logic [1:0]              req_ben,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [2*HALF_WIDTH-1:0] rsp_data,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [2*HALF_WIDTH-1:0] sram_wen,
  output logic [2*HALF_WIDTH-1:0] sram_d,
  input  logic [2*HALF_WIDTH-1:0] sram_q
);

  localparam int unsigned DataWidth = 2 * HALF_WIDTH;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e state_q;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end
`else
  assign state_q = StIdle;
`endif

  assign init_done = (state_q == StIdle);

  // ---------------------------------------------------------------------------
  // Handshake and credit accounting
  // ---------------------------------------------------------------------------
  logic [1:0]           count_q, count_d;
  logic                 inflight_q, inflight_d;
  logic [DataWidth-1:0] fifo_q [2];
  logic [DataWidth-1:0] fifo_d [2];
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DataWidth-1:0] d_q, d_d;

  logic       pop;
  logic       push;
  logic       accept;
  logic [2:0] credit_used;
  logic [1:0] wr_slot;

  assign rsp_vld  = (count_q != 2'd0);
  assign rsp_data = fifo_q[0];
  assign pop      = rsp_vld && rsp_rdy;
  // Read data from the access issued last cycle lands on sram_q now.
  assign push     = inflight_q;

  always_comb begin
    // Slots committed to responses after this cycle's pop; a read is only
    // accepted when it is guaranteed a FIFO slot.
    credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    req_rdy     = cpurst_b && (state_q == StIdle) && (credit_used < 3'd2);
    accept      = req_vld && req_rdy;
    inflight_d  = accept && !req_write;
  end

  // ---------------------------------------------------------------------------
  // Output logic: SRAM pins
  // ---------------------------------------------------------------------------
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_q;
    sram_d    = d_q;
    if (cpurst_b) begin
`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
      if (state_q == StInit) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt_q;
        sram_d    = INIT_DATA;
      end else
`endif
      if (accept) begin
        sram_cen = 1'b0;
        sram_a   = req_addr;
        if (req_write) begin
          sram_gwen = 1'b0;
          sram_wen  = {{HALF_WIDTH{~req_ben[1]}}, {HALF_WIDTH{~req_ben[0]}}};
          sram_d    = req_wdata;
        end
      end
    end
  end

  // A and D hold their last driven values on idle cycles.
  assign a_d = sram_a;
  assign d_d = sram_d;

  // ---------------------------------------------------------------------------
  // Response FIFO: entry 0 is always the head
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_d  = fifo_q;
    wr_slot = count_q - 2'(pop);
    if (pop) begin
      fifo_d[0] = fifo_q[1];
    end
    if (push) begin
      if (wr_slot == 2'd0) begin
        fifo_d[0] = sram_q;
      end else begin
        fifo_d[1] = sram_q;
      end
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

endmodule

// File: tb/tb_ct_spsram_256x54_access_ctrl.sv
// Self-checking bench for ct_spsram_256x54_access_ctrl with a behavioural SRAM
// and a scoreboard of expected read data built from a shadow memory.
module tb_ct_spsram_256x54_access_ctrl;

  localparam int AW = 8;
  localparam int DW = 54;
`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
  localparam logic INIT_DONE_RST = 1'b0;
`else
  localparam logic INIT_DONE_RST = 1'b1;
`endif

  logic          clk, rst_n;
  logic          req_vld, req_rdy, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_ben;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_data;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;

  ct_spsram_256x54_access_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ben       (req_ben),
    .rsp_vld       (rsp_vld),
    .rsp_rdy       (rsp_rdy),
    .rsp_data      (rsp_data),
    .init_done     (init_done),
    .sram_a        (sram_a),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int pops = 0;

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_q [$];
  int            acc_cyc_q [$];
  int            acc_log [$];
  int            lat_q [$];

  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] lo;
    logic [21:0] hi;
    lo = 32'(i) * 32'h9E37_79B9;
    hi = 22'(i * 5 + 3);
    return {hi, lo};
  endfunction

  // Behavioural SRAM: write masked by WEN, read data on Q next cycle.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes, pin protocol, response scoreboard, hold rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_vld", 64'(rsp_vld), 64'd1);
        check("hold_data", 64'(rsp_data), 64'(prev_data));
      end
      prev_hold = rsp_vld && !rsp_rdy;
      prev_data = rsp_data;
      if (req_vld && req_rdy) begin
        check("acc_cen", 64'(sram_cen), 64'd0);
        check("acc_a", 64'(sram_a), 64'(req_addr));
        if (req_write) begin
          check("wr_gwen", 64'(sram_gwen), 64'd0);
          check("wr_wen", 64'(sram_wen), 64'({{27{~req_ben[1]}}, {27{~req_ben[0]}}}));
          check("wr_d", 64'(sram_d), 64'(req_wdata));
          if (req_ben[0]) shadow[req_addr][26:0] = req_wdata[26:0];
          if (req_ben[1]) shadow[req_addr][53:27] = req_wdata[53:27];
        end else begin
          check("rd_gwen", 64'(sram_gwen), 64'd1);
          check("rd_wen", 64'(sram_wen), 64'({DW{1'b1}}));
          exp_q.push_back(shadow[req_addr]);
          acc_cyc_q.push_back(cyc);
          acc_log.push_back(cyc);
          accepts++;
        end
      end else if (init_done) begin
        check("idle_cen", 64'(sram_cen), 64'd1);
      end
      if (rsp_vld && rsp_rdy) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("rsp_without_read", 64'(exp_q.size()), 64'd1);
        end else begin
          check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
          lat_q.push_back(cyc - acc_cyc_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
    check({tag, "_rsp_vld"}, 64'(rsp_vld), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check({tag, "_init_done"}, 64'(init_done), 64'(INIT_DONE_RST));
    check({tag, "_cen"}, 64'(sram_cen), 64'd1);
    check({tag, "_gwen"}, 64'(sram_gwen), 64'd1);
    check({tag, "_wen"}, 64'(sram_wen), 64'({DW{1'b1}}));
    check({tag, "_a"}, 64'(sram_a), 64'd0);
    check({tag, "_d"}, 64'(sram_d), 64'd0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    acc_cyc_q.delete();
    acc_log.delete();
    lat_q.delete();
  endtask

  // Drive one request at posedge+1 and hold it until accepted.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] b);
    int n = 0;
    req_vld = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_ben = b;
    @(negedge clk);
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) check("req_timeout", 64'(req_rdy), 64'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Waits for init_done; counts any rsp_vld seen meanwhile.
  task automatic wait_init(output int stale);
    int n = 0;
    stale = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      if (rsp_vld) stale++;
      n++;
    end
    check("init_timeout", 64'(init_done), 64'd1);
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int took;
    int base;
    int stale;
    int init_bad;
    logic [AW-1:0] addr;

    for (int i = 0; i < 256; i++) begin
      mem[i] = pat(i);
`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
      shadow[i] = '0;
`else
      shadow[i] = pat(i);
`endif
    end
    clk = 1'b0;
    rst_n = 1'b0;
    req_vld = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_ben = 2'b00;
    rsp_rdy = 1'b1;
    #2;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
    // Init sweep with a read of 8'h80 held pending throughout.
    req_vld = 1'b1;
    req_write = 1'b0;
    req_addr = 8'h80;
    init_bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 ||
          sram_a !== 8'(i) || sram_d !== '0 || req_rdy !== 1'b0 || init_done !== 1'b0)
        init_bad++;
    end
    check("init_sweep_bad_cycles", 64'(init_bad), 64'd0);
    @(negedge clk);
    check("init_done_257", 64'(init_done), 64'd1);
    check("init_rdy_257", 64'(req_rdy), 64'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    wait_drain();
`else
    @(negedge clk);
    check("init_done_tied", 64'(init_done), 64'd1);
    @(posedge clk);
    #1;
`endif

    // Write then read the same address in the next cycle.
    lat_q.delete();
    send(1'b1, 8'h05, 54'h3F_FFFF_0123_4567, 2'b11);
    send(1'b0, 8'h05, '0, 2'b00);
    wait_drain();
    check("wr_rd_latency", 64'(lat_q.pop_front()), 64'd2);

    // Lower-half-only write, then a no-op write, each read back.
    send(1'b1, 8'h05, {DW{1'b1}}, 2'b01);
    send(1'b0, 8'h05, '0, 2'b00);
    send(1'b1, 8'h05, '0, 2'b00);
    send(1'b0, 8'h05, '0, 2'b00);
    wait_drain();

    // FIFO full with rsp_rdy low: only two reads may be accepted.
    rsp_rdy = 1'b0;
    base = accepts;
    k = 1;
    for (int c = 0; c < 8; c++) begin
      req_vld = 1'b1;
      req_write = 1'b0;
      req_addr = 8'(k);
      @(negedge clk);
      took = int'(req_rdy);
      @(posedge clk);
      #1;
      if (took != 0) k++;
    end
    req_vld = 1'b0;
    #1;
    check("full_accepts", 64'(accepts - base), 64'd2);
    check("full_req_rdy", 64'(req_rdy), 64'd0);
    check("full_rsp_vld", 64'(rsp_vld), 64'd1);
    check("full_head", 64'(rsp_data), 64'(shadow[1]));
    base = pops;
    rsp_rdy = 1'b1;
    for (; k <= 4; k++) send(1'b0, 8'(k), '0, 2'b00);
    wait_drain();
    check("full_pops", 64'(pops - base), 64'd4);

    // Eight back-to-back reads with rsp_rdy high.
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      addr = 8'h10 + 8'(i);
      send(1'b0, addr, '0, 2'b00);
    end
    wait_drain();
    check("b2b_accepts", 64'(acc_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("b2b_gap", 64'(acc_log[i] - acc_log[0]), 64'(i));
      check("b2b_latency", 64'(lat_q[i]), 64'd2);
    end

    // Reset with a full FIFO: nothing stale may appear afterwards.
    rsp_rdy = 1'b0;
    send(1'b0, 8'h20, '0, 2'b00);
    send(1'b0, 8'h21, '0, 2'b00);
    @(negedge clk);
    check("pre_rst_vld", 64'(rsp_vld), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midop_rst");
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
    wait_init(stale);
`else
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_vld) stale++;
    end
    @(posedge clk);
    #1;
`endif
    check("midop_stale_vld", 64'(stale), 64'd0);
    send(1'b0, 8'h05, '0, 2'b00);
    wait_drain();

`ifdef CT_SPSRAM_ACCESS_CTRL_INIT_EN
    // Reset at INIT address 100 with a read pending.
    send(1'b1, 8'h05, 54'h15_5555_AAAA_5555, 2'b11);
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_vld = 1'b1;
    req_write = 1'b0;
    req_addr = 8'h05;
    repeat (101) @(negedge clk);
    check("init_at_100", 64'(sram_a), 64'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midinit_rst");
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init_restart_a", 64'(sram_a), 64'd0);
    check("init_restart_cen", 64'(sram_cen), 64'd0);
    wait_init(stale);
    check("midinit_stale_vld", 64'(stale), 64'd0);
    req_vld = 1'b0;
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
